// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the hazard, branch and trap detectors and pipeline_ctrl.
// The slave side is the controller and the master side is the requesting logic.
interface pipeline_ctrl_if #(
  parameter int N_STAGES = 5
);
  logic                redirect_in;
  logic                trap_in;
  logic                stall_req_in;
  logic [N_STAGES-1:0] flush_out;
  logic                stall_out;
  logic                pc_en_out;
  logic [1:0]          pc_src_out;

  modport slave (
    input  redirect_in,
    input  trap_in,
    input  stall_req_in,
    output flush_out,
    output stall_out,
    output pc_en_out,
    output pc_src_out
  );

  modport master (
    output redirect_in,
    output trap_in,
    output stall_req_in,
    input  flush_out,
    input  stall_out,
    input  pc_en_out,
    input  pc_src_out
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// STRV32I pipeline control: sequences reset/init/run and turns redirect, trap and
// load-use requests into same-cycle flush, stall and PC control.
module pipeline_ctrl #(
  parameter int          N_STAGES      = 5,
  parameter logic [31:0] REDIRECT_MASK = 32'b00011,
  parameter logic [31:0] TRAP_MASK     = 32'b01111,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          INIT_CYCLES   = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  pipeline_ctrl_if.slave  ctrl
);

  localparam logic [1:0] SRC_RESET    = 2'b00;
  localparam logic [1:0] SRC_REDIRECT = 2'b01;
  localparam logic [1:0] SRC_TRAP     = 2'b10;
  localparam logic [1:0] SRC_SEQ      = 2'b11;

  localparam logic [N_STAGES-1:0] RMASK    = N_STAGES'(REDIRECT_MASK);
  localparam logic [N_STAGES-1:0] TMASK    = N_STAGES'(TRAP_MASK);
  localparam logic [N_STAGES-1:0] SMASK    = N_STAGES'(32'd4);
  localparam logic [N_STAGES-1:0] ALL_ONES = '1;

  localparam int CNT_MAX = (FLUSH_CYCLES > INIT_CYCLES) ? FLUSH_CYCLES : INIT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  // Load values are clamped so degenerate parameter values never produce a negative count.
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'((INIT_CYCLES  > 0) ? INIT_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    S_RESET,
    S_INIT,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [N_STAGES-1:0] mask_q,  mask_d;

  logic [N_STAGES-1:0] flush_d;
  logic                stall_d;
  logic                pc_en_d;
  logic [1:0]          pc_src_d;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    mask_q <= mask_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    flush_d  = '0;
    stall_d  = 1'b0;
    pc_en_d  = 1'b1;
    pc_src_d = SRC_SEQ;

    unique case (state_q)
      S_RESET: begin
        flush_d  = ALL_ONES;
        pc_src_d = SRC_RESET;
        if (INIT_CYCLES == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_INIT;
          cnt_d   = INIT_LOAD;
        end
      end

      S_INIT: begin
        flush_d  = ALL_ONES;
        pc_en_d  = 1'b0;
        pc_src_d = SRC_RESET;
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RUN, S_FLUSH: begin
        if (ctrl.trap_in || ctrl.redirect_in) begin
          // A new event always restarts the flush window, even mid-flush.
          flush_d  = ctrl.trap_in ? TMASK : RMASK;
          pc_src_d = ctrl.trap_in ? SRC_TRAP : SRC_REDIRECT;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
            mask_d  = flush_d;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_FLUSH) begin
          flush_d = mask_q;
          if (cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (ctrl.stall_req_in) begin
          flush_d = SMASK;
          stall_d = 1'b1;
          pc_en_d = 1'b0;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign ctrl.flush_out  = flush_d;
  assign ctrl.stall_out  = stall_d;
  assign ctrl.pc_en_out  = pc_en_d;
  assign ctrl.pc_src_out = pc_src_d;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl over three parameter sets: defaults, a 3-cycle
// flush and a 7-stage core with no init phase.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_checks;
  int   n_pass;

  // Expected {flush, stall, pc_en, pc_src} vectors for the 5-stage instances
  localparam logic [8:0] RST9  = 9'b11111_0_1_00;
  localparam logic [8:0] INIT9 = 9'b11111_0_0_00;
  localparam logic [8:0] RUN9  = 9'b00000_0_1_11;
  localparam logic [8:0] STL9  = 9'b00100_1_0_11;
  localparam logic [8:0] RED9  = 9'b00011_0_1_01;
  localparam logic [8:0] RFL9  = 9'b00011_0_1_11;
  localparam logic [8:0] TRP9  = 9'b01111_0_1_10;
  localparam logic [8:0] TFL9  = 9'b01111_0_1_11;
  // Same layout for the 7-stage instance
  localparam logic [10:0] RST11 = 11'b1111111_0_1_00;
  localparam logic [10:0] RUN11 = 11'b0000000_0_1_11;
  localparam logic [10:0] RED11 = 11'b0000011_0_1_01;
  localparam logic [10:0] TRP11 = 11'b0001111_0_1_10;
  localparam logic [10:0] STL11 = 11'b0000100_1_0_11;

  pipeline_ctrl_if #(.N_STAGES(5)) ifa ();
  pipeline_ctrl_if #(.N_STAGES(5)) ifb ();
  pipeline_ctrl_if #(.N_STAGES(7)) ifc ();

  pipeline_ctrl dut_a (.clk_in(clk), .rst_in(rst_a), .ctrl(ifa));

  pipeline_ctrl #(.FLUSH_CYCLES(3)) dut_b (.clk_in(clk), .rst_in(rst_b), .ctrl(ifb));

  pipeline_ctrl #(.N_STAGES(7), .INIT_CYCLES(0), .FLUSH_CYCLES(1)) dut_c (
    .clk_in(clk), .rst_in(rst_c), .ctrl(ifc)
  );

  logic [8:0]  obs_a, obs_b;
  logic [10:0] obs_c;
  assign obs_a = {ifa.flush_out, ifa.stall_out, ifa.pc_en_out, ifa.pc_src_out};
  assign obs_b = {ifb.flush_out, ifb.stall_out, ifb.pc_en_out, ifb.pc_src_out};
  assign obs_c = {ifc.flush_out, ifc.stall_out, ifc.pc_en_out, ifc.pc_src_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (obs_a !== RST9) $display("FAIL reset_hold%0d: got %b expected %b", i, obs_a, RST9); else n_pass++;
    end
    @(negedge clk); rst_a = 1'b1; #1;
    n_checks++; if (obs_a !== RST9) $display("FAIL reset_release: got %b expected %b", obs_a, RST9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_a !== INIT9) $display("FAIL init0: got %b expected %b", obs_a, INIT9); else n_pass++;
    @(negedge clk); ifa.redirect_in = 1'b1; ifa.trap_in = 1'b1; #1;
    n_checks++; if (obs_a !== INIT9) $display("FAIL init1_ignores_req: got %b expected %b", obs_a, INIT9); else n_pass++;
    @(negedge clk); ifa.redirect_in = 1'b0; ifa.trap_in = 1'b0; #1;
    n_checks++; if (obs_a !== RUN9) $display("FAIL first_run: got %b expected %b", obs_a, RUN9); else n_pass++;
  endtask

  task automatic test_stall;
    @(negedge clk); ifa.stall_req_in = 1'b1; #1;
    n_checks++; if (obs_a !== STL9) $display("FAIL stall0: got %b expected %b", obs_a, STL9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_a !== STL9) $display("FAIL stall1: got %b expected %b", obs_a, STL9); else n_pass++;
    @(negedge clk); ifa.stall_req_in = 1'b0; #1;
    n_checks++; if (obs_a !== RUN9) $display("FAIL stall_resume: got %b expected %b", obs_a, RUN9); else n_pass++;
  endtask

  task automatic test_single_cycle_events;
    @(negedge clk); ifa.redirect_in = 1'b1; #1;
    n_checks++; if (obs_a !== RED9) $display("FAIL redirect_f1: got %b expected %b", obs_a, RED9); else n_pass++;
    @(negedge clk); ifa.redirect_in = 1'b0; #1;
    n_checks++; if (obs_a !== RUN9) $display("FAIL redirect_f1_done: got %b expected %b", obs_a, RUN9); else n_pass++;
    @(negedge clk); ifa.trap_in = 1'b1; #1;
    n_checks++; if (obs_a !== TRP9) $display("FAIL trap_f1: got %b expected %b", obs_a, TRP9); else n_pass++;
    @(negedge clk); ifa.trap_in = 1'b0; #1;
    n_checks++; if (obs_a !== RUN9) $display("FAIL trap_f1_done: got %b expected %b", obs_a, RUN9); else n_pass++;
  endtask

  task automatic test_priority;
    @(negedge clk); ifa.trap_in = 1'b1; ifa.redirect_in = 1'b1; ifa.stall_req_in = 1'b1; #1;
    n_checks++; if (obs_a !== TRP9) $display("FAIL priority_all: got %b expected %b", obs_a, TRP9); else n_pass++;
    @(negedge clk); ifa.trap_in = 1'b0; #1;
    n_checks++; if (obs_a !== RED9) $display("FAIL priority_redir_stall: got %b expected %b", obs_a, RED9); else n_pass++;
    @(negedge clk); ifa.redirect_in = 1'b0; ifa.stall_req_in = 1'b0; #1;
    n_checks++; if (obs_a !== RUN9) $display("FAIL priority_done: got %b expected %b", obs_a, RUN9); else n_pass++;
  endtask

  task automatic test_reset_overrides;
    @(negedge clk); rst_a = 1'b0; ifa.trap_in = 1'b1; #1;
    n_checks++; if (obs_a !== TRP9) $display("FAIL rst_same_cycle_comb: got %b expected %b", obs_a, TRP9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_a !== RST9) $display("FAIL rst_over_trap: got %b expected %b", obs_a, RST9); else n_pass++;
    ifa.trap_in = 1'b0;
  endtask

  task automatic test_redirect_flush;
    @(negedge clk); rst_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (obs_b !== RUN9) $display("FAIL b_first_run: got %b expected %b", obs_b, RUN9); else n_pass++;
    @(negedge clk); ifb.redirect_in = 1'b1; #1;
    n_checks++; if (obs_b !== RED9) $display("FAIL flush3_req: got %b expected %b", obs_b, RED9); else n_pass++;
    @(negedge clk); ifb.redirect_in = 1'b0; ifb.stall_req_in = 1'b1; #1;
    n_checks++; if (obs_b !== RFL9) $display("FAIL flush3_hold1: got %b expected %b", obs_b, RFL9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_b !== RFL9) $display("FAIL flush3_hold2: got %b expected %b", obs_b, RFL9); else n_pass++;
    @(negedge clk); ifb.stall_req_in = 1'b0; #1;
    n_checks++; if (obs_b !== RUN9) $display("FAIL flush3_done: got %b expected %b", obs_b, RUN9); else n_pass++;
  endtask

  task automatic test_midflush_trap;
    @(negedge clk); ifb.redirect_in = 1'b1; #1;
    n_checks++; if (obs_b !== RED9) $display("FAIL mid_redirect: got %b expected %b", obs_b, RED9); else n_pass++;
    @(negedge clk); ifb.redirect_in = 1'b1; ifb.trap_in = 1'b1; #1;
    n_checks++; if (obs_b !== TRP9) $display("FAIL mid_trap: got %b expected %b", obs_b, TRP9); else n_pass++;
    @(negedge clk); ifb.redirect_in = 1'b0; ifb.trap_in = 1'b0; #1;
    n_checks++; if (obs_b !== TFL9) $display("FAIL mid_trap_hold1: got %b expected %b", obs_b, TFL9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_b !== TFL9) $display("FAIL mid_trap_hold2: got %b expected %b", obs_b, TFL9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_b !== RUN9) $display("FAIL mid_trap_done: got %b expected %b", obs_b, RUN9); else n_pass++;
  endtask

  task automatic test_midflush_reset;
    @(negedge clk); ifb.redirect_in = 1'b1; #1;
    n_checks++; if (obs_b !== RED9) $display("FAIL rstflush_req: got %b expected %b", obs_b, RED9); else n_pass++;
    @(negedge clk); ifb.redirect_in = 1'b0; rst_b = 1'b0; #1;
    n_checks++; if (obs_b !== RFL9) $display("FAIL rstflush_pending: got %b expected %b", obs_b, RFL9); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_b !== RST9) $display("FAIL rstflush_reset: got %b expected %b", obs_b, RST9); else n_pass++;
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (obs_b !== INIT9) $display("FAIL rstflush_init: got %b expected %b", obs_b, INIT9); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (obs_b !== RUN9) $display("FAIL rstflush_run: got %b expected %b", obs_b, RUN9); else n_pass++;
  endtask

  task automatic test_param_sweep;
    @(negedge clk); #1;
    n_checks++; if (obs_c !== RST11) $display("FAIL c_reset: got %b expected %b", obs_c, RST11); else n_pass++;
    rst_c = 1'b1; #1;
    n_checks++; if (obs_c !== RST11) $display("FAIL c_release: got %b expected %b", obs_c, RST11); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (obs_c !== RUN11) $display("FAIL c_run: got %b expected %b", obs_c, RUN11); else n_pass++;
    @(negedge clk); ifc.redirect_in = 1'b1; #1;
    n_checks++; if (obs_c !== RED11) $display("FAIL c_redirect: got %b expected %b", obs_c, RED11); else n_pass++;
    @(negedge clk); ifc.redirect_in = 1'b0; #1;
    n_checks++; if (obs_c !== RUN11) $display("FAIL c_redirect_done: got %b expected %b", obs_c, RUN11); else n_pass++;
    @(negedge clk); ifc.trap_in = 1'b1; #1;
    n_checks++; if (obs_c !== TRP11) $display("FAIL c_trap: got %b expected %b", obs_c, TRP11); else n_pass++;
    @(negedge clk); ifc.trap_in = 1'b0; ifc.stall_req_in = 1'b1; #1;
    n_checks++; if (obs_c !== STL11) $display("FAIL c_stall: got %b expected %b", obs_c, STL11); else n_pass++;
    @(negedge clk); ifc.stall_req_in = 1'b0; #1;
    n_checks++; if (obs_c !== RUN11) $display("FAIL c_done: got %b expected %b", obs_c, RUN11); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.redirect_in = 1'b0; ifa.trap_in = 1'b0; ifa.stall_req_in = 1'b0;
    ifb.redirect_in = 1'b0; ifb.trap_in = 1'b0; ifb.stall_req_in = 1'b0;
    ifc.redirect_in = 1'b0; ifc.trap_in = 1'b0; ifc.stall_req_in = 1'b0;

    test_reset;
    test_stall;
    test_single_cycle_events;
    test_priority;
    test_reset_overrides;
    test_redirect_flush;
    test_midflush_trap;
    test_midflush_reset;
    test_param_sweep;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
